// File: rtl/tc_digital_io_ctrl.sv
// Chip-side controller for one tc_digital_io pad: drives the pad controls, filters the
// pad readback, and sequences direction turnaround and retention.
module tc_digital_io_ctrl #(
  parameter int unsigned SyncStages       = 2,
  parameter int unsigned FilterCycles     = 4,
  parameter int unsigned TurnaroundCycles = 2,
  parameter logic [3:0]  DefaultStrength  = 4'h4,
  localparam int unsigned StrengthW       = 4,
  localparam int unsigned PullW           = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cfg_valid_i,
  output logic                 cfg_ready_o,
  input  logic                 cfg_dir_out_i,
  input  logic [StrengthW-1:0] cfg_strength_i,
  input  logic [PullW-1:0]     cfg_pull_i,
  input  logic                 out_data_i,
  output logic                 in_data_o,
  output logic                 in_rise_o,
  output logic                 in_fall_o,
  input  logic                 ret_req_i,
  output logic                 ret_ack_o,
  output logic                 pad_data_o,
  input  logic                 pad_data_i,
  output logic                 pad_oe_no,
  output logic [StrengthW-1:0] pad_strength_o,
  output logic                 pad_pullup_en_o,
  output logic                 pad_pulldown_en_o,
  output logic                 pad_rte_o
);

  localparam int unsigned FiltW = $clog2(FilterCycles + 1);
  localparam int unsigned TurnW = $clog2(TurnaroundCycles + 1);

  typedef enum logic [2:0] {IDLE, TURN, RET_ENTER, RET, RET_EXIT} state_e;

  state_e                 state_q, state_d;
  logic [TurnW-1:0]       turn_cnt_q, turn_cnt_d;
  logic                   dir_q, dir_d;
  logic                   oe_n_q, oe_n_d;
  logic                   data_q, data_d;
  logic [StrengthW-1:0]   strength_q, strength_d;
  logic                   pu_q, pu_d;
  logic                   pd_q, pd_d;
  logic                   rte_q, rte_d;
  logic                   ack_q, ack_d;

  logic [SyncStages-1:0]  sync_q;
  logic [FiltW-1:0]       filt_cnt_q, filt_cnt_d;
  logic                   in_q, in_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;

  assign sync_s      = sync_q[SyncStages-1];
  assign cfg_ready_o = (state_q == IDLE) && !ret_req_i && !rst_i;

  // Control FSM: config acceptance, direction turnaround, retention handshake
  always_comb begin
    state_d    = state_q;
    turn_cnt_d = turn_cnt_q;
    dir_d      = dir_q;
    oe_n_d     = oe_n_q;
    data_d     = data_q;
    strength_d = strength_q;
    pu_d       = pu_q;
    pd_d       = pd_q;
    rte_d      = rte_q;
    ack_d      = ack_q;

    if (!(state_q inside {RET_ENTER, RET, RET_EXIT})) begin
      data_d = out_data_i;
    end

    case (state_q)
      IDLE: begin
        if (ret_req_i) begin
          state_d = RET_ENTER;
          rte_d   = 1'b1;
        end else if (cfg_valid_i) begin
          strength_d = cfg_strength_i;
          pu_d       = (cfg_pull_i == 2'b01);
          pd_d       = (cfg_pull_i == 2'b10);
          if (cfg_dir_out_i != dir_q) begin
            oe_n_d     = 1'b1;
            turn_cnt_d = '0;
            state_d    = TURN;
          end
        end
      end
      TURN: begin
        if (turn_cnt_q == TurnW'(TurnaroundCycles - 1)) begin
          dir_d      = ~dir_q;
          oe_n_d     = dir_q;
          turn_cnt_d = '0;
          state_d    = IDLE;
        end else begin
          turn_cnt_d = turn_cnt_q + TurnW'(1);
        end
      end
      RET_ENTER: begin
        ack_d   = 1'b1;
        state_d = RET;
      end
      RET: begin
        if (!ret_req_i) begin
          rte_d   = 1'b0;
          state_d = RET_EXIT;
        end
      end
      RET_EXIT: begin
        ack_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Glitch filter: toggle only after FilterCycles consecutive differing synced samples
  always_comb begin
    filt_cnt_d = '0;
    in_d       = in_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    if (sync_s != in_q) begin
      if (filt_cnt_q == FiltW'(FilterCycles - 1)) begin
        in_d   = sync_s;
        rise_d = sync_s;
        fall_d = ~sync_s;
      end else begin
        filt_cnt_d = filt_cnt_q + FiltW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      turn_cnt_q <= '0;
      dir_q      <= 1'b0;
      oe_n_q     <= 1'b1;
      data_q     <= 1'b0;
      strength_q <= DefaultStrength;
      pu_q       <= 1'b0;
      pd_q       <= 1'b0;
      rte_q      <= 1'b0;
      ack_q      <= 1'b0;
      sync_q     <= '0;
      filt_cnt_q <= '0;
      in_q       <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
    end else begin
      turn_cnt_q <= turn_cnt_d;
      dir_q      <= dir_d;
      oe_n_q     <= oe_n_d;
      data_q     <= data_d;
      strength_q <= strength_d;
      pu_q       <= pu_d;
      pd_q       <= pd_d;
      rte_q      <= rte_d;
      ack_q      <= ack_d;
      sync_q     <= {sync_q[SyncStages-2:0], pad_data_i};
      filt_cnt_q <= filt_cnt_d;
      in_q       <= in_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
    end
  end

  assign in_data_o         = in_q;
  assign in_rise_o         = rise_q;
  assign in_fall_o         = fall_q;
  assign ret_ack_o         = ack_q;
  assign pad_data_o        = data_q;
  assign pad_oe_no         = oe_n_q;
  assign pad_strength_o    = strength_q;
  assign pad_pullup_en_o   = pu_q;
  assign pad_pulldown_en_o = pd_q;
  assign pad_rte_o         = rte_q;

endmodule
